// File: rtl/pll_dyn_cfg_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pll_dyn_cfg_ctrl
// Purpose  : Loads PLL divider ratios, sequences PLL reset and qualifies lock.
// Revision : 1.0
// ============================================================================
module pll_dyn_cfg_ctrl #(
    parameter int         RST_CYCLES    = 16,
    parameter int         LOCK_TIMEOUT  = 65535,
    parameter int         STABLE_CYCLES = 8,
    parameter int         MAX_RETRY     = 3,
    parameter logic [9:0] INIT_IDIV     = 10'd4,
    parameter logic [9:0] INIT_ODIV0    = 10'd8,
    parameter logic [9:0] INIT_ODIV1    = 10'd119,
    parameter logic [9:0] INIT_FDIV     = 10'd95
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    input  logic [9:0] cfg_idiv,
    input  logic [9:0] cfg_odiv0,
    input  logic [9:0] cfg_odiv1,
    input  logic [9:0] cfg_fdiv,
    output logic [9:0] dyn_idiv,
    output logic [9:0] dyn_odiv0,
    output logic [9:0] dyn_odiv1,
    output logic [9:0] dyn_fdiv,
    output logic [9:0] dyn_duty0,
    output logic [9:0] dyn_duty1,
    output logic       pll_rst,
    input  logic       pll_lock,
    output logic       locked,
    output logic       cfg_done,
    output logic       cfg_err,
    output logic       lock_lost
);
    localparam int RCW = (RST_CYCLES    > 1) ? $clog2(RST_CYCLES)    : 1;
    localparam int TCW = (LOCK_TIMEOUT  > 1) ? $clog2(LOCK_TIMEOUT)  : 1;
    localparam int SCW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam int RTW = (MAX_RETRY     > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [RCW-1:0] c_RST_LAST = RCW'(RST_CYCLES - 1);
    localparam logic [TCW-1:0] c_TMO_LAST = TCW'(LOCK_TIMEOUT - 1);
    localparam logic [SCW-1:0] c_STB_LAST = SCW'(STABLE_CYCLES - 1);
    localparam logic [RTW-1:0] c_RTY_MAX  = RTW'(MAX_RETRY);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RST    = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_STABLE = 3'd3;
    localparam logic [2:0] S_FAIL   = 3'd4;

    logic [2:0]     r_state;
    logic [2:0]     w_next;
    logic           r_sync1, r_sync2;
    logic [RCW-1:0] r_rst_cnt;
    logic [TCW-1:0] r_tmo_cnt;
    logic [SCW-1:0] r_stb_cnt;
    logic [RTW-1:0] r_retry;
    logic           r_locked, r_cfg_done, r_cfg_err, r_lock_lost;
    logic [9:0]     r_idiv, r_odiv0, r_odiv1, r_fdiv;
    logic           w_lock_s, w_drop, w_ready, w_cfg_ok;
    logic           w_done, w_err, w_lost, w_load, w_fail, w_retry_inc, w_retry_clr;

    assign w_lock_s = r_sync2;
    assign w_drop   = r_locked & ~w_lock_s;
    assign w_cfg_ok = (cfg_idiv != '0) && (cfg_odiv0 != '0) &&
                      (cfg_odiv1 != '0) && (cfg_fdiv != '0);

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_RST;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_done      = 1'b0;
        w_err       = 1'b0;
        w_lost      = 1'b0;
        w_load      = 1'b0;
        w_fail      = 1'b0;
        w_retry_inc = 1'b0;
        w_retry_clr = 1'b0;
        case (r_state)
            S_IDLE: begin
                // A lock drop wins over a coincident request.
                if (w_drop) begin
                    w_lost      = 1'b1;
                    w_retry_clr = 1'b1;
                    w_next      = S_RST;
                end else if (cfg_valid && w_ready) begin
                    if (w_cfg_ok) begin
                        w_load      = 1'b1;
                        w_retry_clr = 1'b1;
                        w_next      = S_RST;
                    end else begin
                        w_err = 1'b1;
                    end
                end
            end
            S_RST: begin
                if (r_rst_cnt == c_RST_LAST) w_next = S_WAIT;
            end
            S_WAIT: begin
                if (w_lock_s) begin
                    if (STABLE_CYCLES <= 1) begin
                        w_done = 1'b1;
                        w_next = S_IDLE;
                    end else begin
                        w_next = S_STABLE;
                    end
                end else if (r_tmo_cnt == c_TMO_LAST) begin
                    w_fail = 1'b1;
                end
            end
            S_STABLE: begin
                if (!w_lock_s) begin
                    w_next = S_WAIT;
                end else if (r_stb_cnt == c_STB_LAST) begin
                    w_done = 1'b1;
                    w_next = S_IDLE;
                end
            end
            S_FAIL:  w_next = S_FAIL;
            default: w_next = S_RST;
        endcase
        if (w_fail) begin
            if (r_retry < c_RTY_MAX) begin
                w_retry_inc = 1'b1;
                w_next      = S_RST;
            end else begin
                w_err  = 1'b1;
                w_next = S_FAIL;
            end
        end
    end

    always_comb begin
        pll_rst = 1'b0;
        w_ready = 1'b0;
        if (r_state == S_RST)  pll_rst = 1'b1;
        if (r_state == S_IDLE) w_ready = ~w_drop;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1     <= 1'b0;
            r_sync2     <= 1'b0;
            r_rst_cnt   <= '0;
            r_tmo_cnt   <= '0;
            r_stb_cnt   <= '0;
            r_retry     <= '0;
            r_locked    <= 1'b0;
            r_cfg_done  <= 1'b0;
            r_cfg_err   <= 1'b0;
            r_lock_lost <= 1'b0;
            r_idiv      <= INIT_IDIV;
            r_odiv0     <= INIT_ODIV0;
            r_odiv1     <= INIT_ODIV1;
            r_fdiv      <= INIT_FDIV;
        end else begin
            r_sync1     <= pll_lock;
            r_sync2     <= r_sync1;
            r_cfg_done  <= w_done;
            r_cfg_err   <= w_err;
            r_lock_lost <= w_lost;
            if (w_load) begin
                r_idiv  <= cfg_idiv;
                r_odiv0 <= cfg_odiv0;
                r_odiv1 <= cfg_odiv1;
                r_fdiv  <= cfg_fdiv;
            end
            if (r_state == S_RST && r_rst_cnt != c_RST_LAST) r_rst_cnt <= r_rst_cnt + RCW'(1);
            else                                             r_rst_cnt <= '0;
            // Timeout only advances in LOCK_WAIT and survives trips through LOCK_STABLE.
            if (r_state == S_RST) r_tmo_cnt <= '0;
            else if (r_state == S_WAIT && !w_lock_s && r_tmo_cnt != c_TMO_LAST)
                r_tmo_cnt <= r_tmo_cnt + TCW'(1);
            if (r_state == S_WAIT) r_stb_cnt <= SCW'(1);
            else if (r_state == S_STABLE && w_lock_s && r_stb_cnt != c_STB_LAST)
                r_stb_cnt <= r_stb_cnt + SCW'(1);
            if (w_retry_clr)      r_retry <= '0;
            else if (w_retry_inc) r_retry <= r_retry + RTW'(1);
            if (w_done)                 r_locked <= 1'b1;
            else if (w_next != S_IDLE)  r_locked <= 1'b0;
        end
    end

    assign cfg_ready = w_ready;
    assign locked    = r_locked;
    assign cfg_done  = r_cfg_done;
    assign cfg_err   = r_cfg_err;
    assign lock_lost = r_lock_lost;
    assign dyn_idiv  = r_idiv;
    assign dyn_odiv0 = r_odiv0;
    assign dyn_odiv1 = r_odiv1;
    assign dyn_fdiv  = r_fdiv;
    assign dyn_duty0 = r_odiv0;
    assign dyn_duty1 = r_odiv1;

endmodule
`default_nettype wire

// File: tb/tb_pll_dyn_cfg_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pll_dyn_cfg_ctrl
// Purpose  : Randomized self-checking bench with a behavioural PLL and model.
// Revision : 1.0
// ============================================================================
module tb_pll_dyn_cfg_ctrl;
    logic       clk = 1'b0;
    logic       rst, cfg_valid, cfg_ready, pll_rst, pll_lock, locked;
    logic       cfg_done, cfg_err, lock_lost;
    logic [9:0] cfg_idiv, cfg_odiv0, cfg_odiv1, cfg_fdiv;
    logic [9:0] dyn_idiv, dyn_odiv0, dyn_odiv1, dyn_fdiv, dyn_duty0, dyn_duty1;

    pll_dyn_cfg_ctrl #(
        .RST_CYCLES(4), .LOCK_TIMEOUT(20), .STABLE_CYCLES(3), .MAX_RETRY(1)
    ) u_dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_idiv(cfg_idiv), .cfg_odiv0(cfg_odiv0), .cfg_odiv1(cfg_odiv1), .cfg_fdiv(cfg_fdiv),
        .dyn_idiv(dyn_idiv), .dyn_odiv0(dyn_odiv0), .dyn_odiv1(dyn_odiv1), .dyn_fdiv(dyn_fdiv),
        .dyn_duty0(dyn_duty0), .dyn_duty1(dyn_duty1), .pll_rst(pll_rst), .pll_lock(pll_lock),
        .locked(locked), .cfg_done(cfg_done), .cfg_err(cfg_err), .lock_lost(lock_lost)
    );

    always #5 clk = ~clk;

    // Behavioural PLL: loses lock in reset, relocks lock_delay cycles after release.
    logic use_auto = 1'b0, man_lock = 1'b0, auto_lock;
    int   auto_cnt = 0, lock_delay = 0;
    always @(posedge clk) begin
        if (pll_rst)             auto_cnt <= 0;
        else if (auto_cnt < 255) auto_cnt <= auto_cnt + 1;
    end
    assign auto_lock = !pll_rst && (auto_cnt >= lock_delay);
    assign pll_lock  = use_auto ? auto_lock : man_lock;

    int n_chk = 0, n_pass = 0;
    int n_done = 0, n_err = 0, n_lost = 0, n_both = 0, n_duty_bad = 0, run = 0;
    int runs[$];

    always @(negedge clk) begin
        if (rst) run = 0;
        else begin
            if (pll_rst) run++;
            else if (run != 0) begin runs.push_back(run); run = 0; end
            if (cfg_done) n_done++;
            if (cfg_err) n_err++;
            if (lock_lost) n_lost++;
            if (cfg_done && cfg_err) n_both++;
            if (dyn_duty0 != dyn_odiv0 || dyn_duty1 != dyn_odiv1) n_duty_bad++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string tag, input int budget);
        bit found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            step(1);
            if (cfg_done) found = 1'b1;
        end
        chk(tag, 32'(found), 1);
    endtask

    logic [9:0] exp_idiv, exp_odiv0, exp_odiv1, exp_fdiv;
    logic [9:0] ri, ro0, ro1, rf;

    task automatic chk_dyn(input string tag);
        chk({tag, "_idiv"},  32'(dyn_idiv),  32'(exp_idiv));
        chk({tag, "_odiv0"}, 32'(dyn_odiv0), 32'(exp_odiv0));
        chk({tag, "_odiv1"}, 32'(dyn_odiv1), 32'(exp_odiv1));
        chk({tag, "_fdiv"},  32'(dyn_fdiv),  32'(exp_fdiv));
    endtask

    task automatic drive_cfg(input logic [9:0] a, input logic [9:0] b,
                             input logic [9:0] c, input logic [9:0] d);
        cfg_idiv = a; cfg_odiv0 = b; cfg_odiv1 = c; cfg_fdiv = d;
    endtask

    task automatic set_init_model();
        exp_idiv = 10'd4; exp_odiv0 = 10'd8; exp_odiv1 = 10'd119; exp_fdiv = 10'd95;
    endtask

    initial begin
        int  b_done, b_err, b_lost, nr, seen;
        bit  bad, flag;
        bit  pat [6];
        pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        rst = 1'b1; cfg_valid = 1'b0; drive_cfg(10'd0, 10'd0, 10'd0, 10'd0);
        set_init_model();

        // Reset values
        step(3);
        chk("rst_pll_rst", 32'(pll_rst), 1);
        chk("rst_locked", 32'(locked), 0);
        chk("rst_ready", 32'(cfg_ready), 0);
        chk("rst_pulses", 32'({cfg_done, cfg_err, lock_lost}), 0);
        chk_dyn("rst");

        // Power-up with lock arriving at cycle 6
        nr = runs.size(); b_done = n_done;
        rst = 1'b0;
        seen = -1;
        for (int c = 1; c < 60 && seen < 0; c++) begin
            step(1);
            if (c >= 6) man_lock = 1'b1;
            if (cfg_done) seen = c;
        end
        chk("pwr_done_seen", 32'(seen > 0), 1);
        chk("pwr_ready", 32'(cfg_ready), 1);
        step(3);
        chk("pwr_rst_len", 32'(runs.size() > nr ? runs[nr] : -1), 4);
        chk("pwr_done_cnt", 32'(n_done - b_done), 1);
        chk("pwr_locked", 32'(locked), 1);
        chk("pwr_odiv1", 32'(dyn_odiv1), 119);

        // Random requests against a relocking PLL
        use_auto = 1'b1;
        for (int k = 0; k < 10; k++) begin
            ri = 10'($urandom_range(1, 1023)); ro0 = 10'($urandom_range(1, 1023));
            ro1 = 10'($urandom_range(1, 1023)); rf = 10'($urandom_range(1, 1023));
            bad = ($urandom_range(0, 2) == 0);
            if (k == 0) begin bad = 1'b1; ro1 = 10'd0; end
            else if (k == 1) begin bad = 1'b0; ri = 10'd5; ro0 = 10'd10; ro1 = 10'd50; rf = 10'd100; end
            else if (bad) begin
                case ($urandom_range(0, 3))
                    0: ri = 10'd0;
                    1: ro0 = 10'd0;
                    2: ro1 = 10'd0;
                    default: rf = 10'd0;
                endcase
            end
            lock_delay = int'($urandom_range(0, 6));
            b_done = n_done; b_err = n_err; nr = runs.size();
            drive_cfg(ri, ro0, ro1, rf); cfg_valid = 1'b1;
            chk("req_ready", 32'(cfg_ready), 1);
            step(1);
            cfg_valid = 1'b0;
            if (!bad) begin
                exp_idiv = ri; exp_odiv0 = ro0; exp_odiv1 = ro1; exp_fdiv = rf;
                chk_dyn("req_load");
                chk("req_duty0", 32'(dyn_duty0), 32'(ro0));
                chk("req_duty1", 32'(dyn_duty1), 32'(ro1));
                chk("req_unlocked", 32'(locked), 0);
                chk("req_pll_rst", 32'(pll_rst), 1);
                wait_done("req_done", 80);
                step(2);
                chk("req_rst_len", 32'(runs.size() == nr + 1 ? runs[nr] : -1), 4);
                chk("req_done_cnt", 32'(n_done - b_done), 1);
                chk("req_err_cnt", 32'(n_err - b_err), 0);
                chk("req_locked", 32'(locked), 1);
            end else begin
                chk("bad_err", 32'(cfg_err), 1);
                chk_dyn("bad_keep");
                chk("bad_locked", 32'(locked), 1);
                chk("bad_no_rst", 32'(pll_rst), 0);
                step(2);
                chk("bad_err_cnt", 32'(n_err - b_err), 1);
                chk("bad_done_cnt", 32'(n_done - b_done), 0);
                chk("bad_no_run", 32'(runs.size()), 32'(nr));
                chk("bad_ready", 32'(cfg_ready), 1);
            end
        end

        // Lock drop coinciding with a request
        man_lock = 1'b1; use_auto = 1'b0;
        step(2);
        b_done = n_done; b_err = n_err; b_lost = n_lost;
        man_lock = 1'b0; step(1);
        man_lock = 1'b1; step(1);
        drive_cfg(10'd33, 10'd44, 10'd55, 10'd66); cfg_valid = 1'b1;
        chk("drop_ready", 32'(cfg_ready), 0);
        step(1);
        cfg_valid = 1'b0;
        chk("drop_lost", 32'(lock_lost), 1);
        chk("drop_locked", 32'(locked), 0);
        chk("drop_pll_rst", 32'(pll_rst), 1);
        wait_done("drop_relock", 60);
        step(2);
        chk_dyn("drop_keep");
        chk("drop_lost_cnt", 32'(n_lost - b_lost), 1);
        chk("drop_done_cnt", 32'(n_done - b_done), 1);
        chk("drop_err_cnt", 32'(n_err - b_err), 0);

        // Timeout kept across a short lock, then glitchy lock on the retry
        b_done = n_done; b_err = n_err; nr = runs.size();
        drive_cfg(10'd12, 10'd34, 10'd56, 10'd78); cfg_valid = 1'b1; man_lock = 1'b0;
        step(1);
        cfg_valid = 1'b0;
        exp_idiv = 10'd12; exp_odiv0 = 10'd34; exp_odiv1 = 10'd56; exp_fdiv = 10'd78;
        for (int g = 0; g < 10 && pll_rst; g++) step(1);
        seen = -1;
        for (int c = 0; c < 40 && seen < 0; c++) begin
            if (c > 0 && pll_rst) seen = c;
            else begin
                man_lock = (c == 10 || c == 11);
                step(1);
            end
        end
        chk("tmo_retry_cycle", 32'(seen), 23);
        for (int g = 0; g < 10 && pll_rst; g++) step(1);
        seen = -1;
        for (int c = 0; c < 30 && seen < 0; c++) begin
            if (cfg_done) seen = c;
            else begin
                man_lock = (c < 6) ? pat[c] : 1'b1;
                step(1);
            end
        end
        chk("glitch_done_cycle", 32'(seen), 8);
        step(2);
        chk("glitch_done_cnt", 32'(n_done - b_done), 1);
        chk("glitch_err_cnt", 32'(n_err - b_err), 0);
        chk("glitch_runs", 32'(runs.size() - nr), 2);
        chk("glitch_locked", 32'(locked), 1);
        chk_dyn("glitch");

        // Reset mid-sequence, then total lock failure
        drive_cfg(10'd7, 10'd9, 10'd11, 10'd13); cfg_valid = 1'b1; man_lock = 1'b0;
        step(1);
        cfg_valid = 1'b0;
        chk("abort_loaded", 32'(dyn_idiv), 7);
        step(1);
        rst = 1'b1;
        step(1);
        set_init_model();
        chk_dyn("abort");
        chk("abort_pll_rst", 32'(pll_rst), 1);
        chk("abort_locked", 32'(locked), 0);
        chk("abort_ready", 32'(cfg_ready), 0);
        step(1);
        b_done = n_done; b_err = n_err; nr = runs.size();
        rst = 1'b0;
        seen = -1;
        for (int c = 1; c < 70 && seen < 0; c++) begin
            step(1);
            if (cfg_err) seen = c;
        end
        chk("fail_err_cycle", 32'(seen), 48);
        flag = 1'b0;
        drive_cfg(10'd1, 10'd2, 10'd3, 10'd4); cfg_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step(1);
            if (cfg_ready || pll_rst || locked || cfg_err || cfg_done) flag = 1'b1;
        end
        cfg_valid = 1'b0;
        chk("fail_hold", 32'(flag), 0);
        chk_dyn("fail_keep");
        chk("fail_runs", 32'(runs.size() - nr), 2);
        chk("fail_run0", 32'(runs.size() >= nr + 2 ? runs[nr] : -1), 4);
        chk("fail_run1", 32'(runs.size() >= nr + 2 ? runs[nr + 1] : -1), 4);
        chk("fail_err_cnt", 32'(n_err - b_err), 1);
        chk("fail_done_cnt", 32'(n_done - b_done), 0);

        // Recovery from FAIL only through reset
        rst = 1'b1; use_auto = 1'b1; lock_delay = 2;
        step(2);
        rst = 1'b0;
        wait_done("recover_done", 80);
        step(2);
        chk("recover_locked", 32'(locked), 1);
        chk("recover_ready", 32'(cfg_ready), 1);
        chk_dyn("recover");
        chk("never_done_and_err", 32'(n_both), 0);
        chk("duty_tracks_odiv", 32'(n_duty_bad), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/pll_dyn_cfg_ctrl.md
PLL_DYN_CFG_CTRL -- requirements
Module: pll_dyn_cfg_ctrl

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 16: cycles pll_rst is held high per attempt (>=1).
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 65535: LOCK_WAIT cycles before an attempt fails.
REQ-003 SHALL have parameter STABLE_CYCLES, default 8: consecutive synced-lock-high cycles required to declare lock.
REQ-004 SHALL have parameter MAX_RETRY, default 3: extra attempts after the first failure.
REQ-005 SHALL have parameters INIT_IDIV 4, INIT_ODIV0 8, INIT_ODIV1 119, INIT_FDIV 95: ratios loaded at reset.
REQ-006 SHALL have port clk, input, 1: single clock, free-running 50 MHz reference.
REQ-007 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-008 SHALL have port cfg_valid, input, 1: new ratio set requested.
REQ-009 SHALL have port cfg_ready, output, 1: accepting a request.
REQ-010 SHALL have ports cfg_idiv, cfg_odiv0, cfg_odiv1, cfg_fdiv, input, 10 each: requested ratios.
REQ-011 SHALL have ports dyn_idiv, dyn_odiv0, dyn_odiv1, dyn_fdiv, dyn_duty0, dyn_duty1, output, 10 each: to PLL dynamic ports.
REQ-012 SHALL have port pll_rst, output, 1: PLL reset.
REQ-013 SHALL have port pll_lock, input, 1: raw, asynchronous PLL lock.
REQ-014 SHALL have port locked, output, 1: qualified, stable lock.
REQ-015 SHALL have ports cfg_done, cfg_err, lock_lost, output, 1 each: single-cycle status pulses.

Function
REQ-016 SHALL pass pll_lock through a two-flop synchronizer; lock_s is the second flop's output.
REQ-017 SHALL implement states IDLE, RST_ASSERT, LOCK_WAIT, LOCK_STABLE, FAIL.
REQ-018 SHALL assert cfg_ready only in IDLE; a transfer occurs when cfg_valid and cfg_ready are both high on a rising clk edge.
REQ-019 On transfer with all four ratios nonzero: SHALL register them into dyn_* next cycle, clear retry count, and enter RST_ASSERT.
REQ-020 On transfer with any ratio zero: SHALL pulse cfg_err next cycle, leave dyn_* unchanged, and remain in IDLE with locked unchanged.
REQ-021 SHALL drive dyn_duty0 = dyn_odiv0 and dyn_duty1 = dyn_odiv1 at all times (50% duty).
REQ-022 In RST_ASSERT: pll_rst=1 and locked=0 for exactly RST_CYCLES cycles, then enter LOCK_WAIT with pll_rst=0.
REQ-023 In LOCK_WAIT: on lock_s=1, enter LOCK_STABLE with stable counter 1; if LOCK_TIMEOUT cycles elapse without lock_s, the attempt fails.
REQ-024 In LOCK_STABLE: on lock_s=0, return to LOCK_WAIT without resetting the timeout counter; after STABLE_CYCLES consecutive high cycles, go to IDLE, set locked=1, and pulse cfg_done.
REQ-025 On a failed attempt with retries used < MAX_RETRY: SHALL increment the retry count and re-enter RST_ASSERT; otherwise enter FAIL and pulse cfg_err.
REQ-026 FAIL SHALL hold pll_rst=0, locked=0, and cfg_ready=0 until rst.
REQ-027 In IDLE with locked=1 and lock_s=0: SHALL clear locked, pulse lock_lost, and enter RST_ASSERT with the same ratios, the retry count cleared, and no cfg_done/cfg_err for the detection itself.
REQ-028 If a lock drop and cfg_valid coincide in IDLE, the lock drop SHALL take priority; cfg_ready SHALL be 0 that cycle and no transfer occurs.
REQ-029 Counters SHALL be sized from their parameters and SHALL NOT wrap; the timeout counter saturates.
REQ-030 cfg_done and cfg_err SHALL never assert in the same cycle.

Reset
REQ-031 While rst=1: state RST_ASSERT with counters cleared; dyn_* = INIT_* values; pll_rst=1; locked, cfg_ready, cfg_done, cfg_err, lock_lost = 0; synchronizer flops = 0.
REQ-032 After rst deasserts, SHALL run the power-up sequence (REQ-022..026) automatically with the INIT_* ratios.
REQ-033 rst asserted mid-sequence SHALL abort it immediately and discard any registered request in favour of the INIT_* ratios.

Verification (RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=3, MAX_RETRY=1)
REQ-034 Release rst, pll_lock=1 from cycle 6 -> pll_rst high exactly 4 cycles, cfg_done once, locked=1, dyn_odiv1=119.
REQ-035 Locked; request idiv=5, odiv0=10, odiv1=50, fdiv=100 -> dyn_odiv0=10 and dyn_duty0=10 next cycle, pll_rst pulse 4 cycles, cfg_done after lock.
REQ-036 Request with cfg_odiv1=0 -> cfg_err pulse, dyn_* unchanged, locked stays 1, no pll_rst.
REQ-037 pll_lock held 0 -> two 4-cycle pll_rst pulses, each followed by a 20-cycle timeout, then FAIL with a cfg_err pulse and cfg_ready=0 until rst.
REQ-038 Locked; pll_lock drops for 1 cycle while cfg_valid=1 -> lock_lost pulse, request not accepted, relock sequence with the old ratios.
REQ-039 pll_lock toggling 1,1,0,1,1,1 during LOCK_STABLE -> cfg_done only after the 3-high run; timeout not reset.
